tuple_pipe_arbiter: RTL and testbench

//  Shares one fixed-latency 8-bit tuple pipeline (two 4-bit halves in, one byte out)

---
 rtl/tuple_arb_pkg.sv | 15 +
 rtl/tuple_tag_pipe.sv | 40 ++++
 rtl/tuple_pipe_arbiter.sv | 90 +++++++++
 tb/tb_tuple_pipe_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tuple_arb_pkg.sv
// Shared types and widths for the two-requester tuple pipeline arbiter.
package tuple_arb_pkg;

  localparam int RESULT_W = 8;
  localparam int HALF_W   = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/tuple_tag_pipe.sv
// Fixed-depth shift of a requester tag alongside its data byte.
module tuple_tag_pipe
  import tuple_arb_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  tag_t                in_tag,
  input  logic [RESULT_W-1:0] in_data,
  output tag_t                out_tag,
  output logic [RESULT_W-1:0] out_data
);

  tag_t                tags [LATENCY];
  logic [RESULT_W-1:0] data [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  // NOTE: the data stages carry no reset; the tag valid bit alone says whether
  // a stage holds meaningful data, so resetting this storage buys nothing.
  // Each stage loads only behind a valid tag, so bubbles leave the last byte intact.
  always_ff @(posedge clk) begin
    if (in_tag.valid) data[0] <= in_data;
    for (int i = 1; i < LATENCY; i++) begin
      if (tags[i-1].valid) data[i] <= data[i-1];
    end
  end

  assign out_tag  = tags[LATENCY-1];
  assign out_data = data[LATENCY-1];

endmodule

// File: rtl/tuple_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency tuple pipeline between requesters A and B.
module tuple_pipe_arbiter
  import tuple_arb_pkg::*;
#(
  parameter int LATENCY         = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  input  logic [HALF_W-1:0]   a_hi,
  input  logic [HALF_W-1:0]   a_lo,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [HALF_W-1:0]   b_hi,
  input  logic [HALF_W-1:0]   b_lo,
  output logic                b_ready,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic [RESULT_W-1:0] result
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_a, cnt_b;
  logic                ptr;
  logic                seen;
  logic                ret_a, ret_b;
  logic                elig_a, elig_b;
  logic                issue_a, issue_b;
  tag_t                in_tag, out_tag;
  logic [RESULT_W-1:0] in_data, out_data;

  assign ret_a = out_tag.valid && (out_tag.id == REQ_A);
  assign ret_b = out_tag.valid && (out_tag.id == REQ_B);

  // A returning result frees its slot in the same cycle.
  assign elig_a = a_valid && !((cnt_a == CNT_MAX) && !ret_a);
  assign elig_b = b_valid && !((cnt_b == CNT_MAX) && !ret_b);

  assign issue_a = rst_n && elig_a && (!elig_b || ptr == REQ_A);
  assign issue_b = rst_n && elig_b && (!elig_a || ptr == REQ_B);
  assign a_ready = issue_a;
  assign b_ready = issue_b;

  assign in_tag.valid = issue_a || issue_b;
  assign in_tag.id    = issue_b ? REQ_B : REQ_A;
  assign in_data      = issue_b ? {b_hi, b_lo} : {a_hi, a_lo};

  tuple_tag_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .out_tag  (out_tag),
    .out_data (out_data)
  );

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
      ptr   <= REQ_A;
      seen  <= 1'b0;
    end else begin
      case ({issue_a, ret_a})
        2'b10:   cnt_a <= cnt_a + CNT_ONE;
        2'b01:   cnt_a <= cnt_a - CNT_ONE;
        default: cnt_a <= cnt_a;
      endcase
      case ({issue_b, ret_b})
        2'b10:   cnt_b <= cnt_b + CNT_ONE;
        2'b01:   cnt_b <= cnt_b - CNT_ONE;
        default: cnt_b <= cnt_b;
      endcase
      if (elig_a && elig_b) ptr <= ~ptr;
      if (out_tag.valid)    seen <= 1'b1;
    end
  end

  // Until the first result since reset the unreset data stage is masked to zero.
  assign a_rvalid = ret_a;
  assign b_rvalid = ret_b;
  assign result   = (seen || out_tag.valid) ? out_data : '0;

endmodule

// File: tb/tb_tuple_pipe_arbiter.sv
// Directed and random checks of tuple_pipe_arbiter against a transaction-queue model.
module tb_tuple_pipe_arbiter;

  localparam int LAT = 3;
  localparam int MAX = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic [3:0] a_hi, a_lo, b_hi, b_lo;
  logic       a_ready, b_ready, a_rvalid, b_rvalid;
  logic [7:0] result;

  tuple_pipe_arbiter #(.LATENCY(LAT), .MAX_OUTSTANDING(MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_hi     (a_hi),
    .a_lo     (a_lo),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_hi     (b_hi),
    .b_lo     (b_lo),
    .b_ready  (b_ready),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .result   (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } txn_t;

  txn_t       pend[$];
  int         out_a, out_b, cyc;
  bit         ptr;
  logic [7:0] last_res;
  bit         a_issued, b_issued;

  logic       obs_a_ready, obs_b_ready, obs_a_rvalid, obs_b_rvalid;
  logic [7:0] obs_result;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    pend.delete();
    out_a    = 0;
    out_b    = 0;
    ptr      = 1'b0;
    last_res = 8'h00;
    a_issued = 1'b0;
    b_issued = 1'b0;
  endtask

  // One cycle: check outputs after inputs settle, then advance the model at the edge.
  task automatic step();
    bit         ret, ret_id, ea, eb, ga, gb;
    logic [7:0] ret_data, er;
    #1;
    obs_a_ready  = a_ready;
    obs_b_ready  = b_ready;
    obs_a_rvalid = a_rvalid;
    obs_b_rvalid = b_rvalid;
    obs_result   = result;
    if (!rst_n) begin
      check("rst_a_ready",  {7'b0, a_ready},  8'h00);
      check("rst_b_ready",  {7'b0, b_ready},  8'h00);
      check("rst_a_rvalid", {7'b0, a_rvalid}, 8'h00);
      check("rst_b_rvalid", {7'b0, b_rvalid}, 8'h00);
      check("rst_result",   result,           8'h00);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      return;
    end
    ret      = (pend.size() > 0) && (pend[0].due == cyc);
    ret_id   = ret ? pend[0].id : 1'b0;
    ret_data = ret ? pend[0].data : 8'h00;
    ea = a_valid && ((out_a - int'(ret && !ret_id)) < MAX);
    eb = b_valid && ((out_b - int'(ret &&  ret_id)) < MAX);
    ga = ea && (!eb || !ptr);
    gb = eb && (!ea ||  ptr);
    er = ret ? ret_data : last_res;
    check("a_ready",  {7'b0, a_ready},  {7'b0, ga});
    check("b_ready",  {7'b0, b_ready},  {7'b0, gb});
    check("a_rvalid", {7'b0, a_rvalid}, {7'b0, ret && !ret_id});
    check("b_rvalid", {7'b0, b_rvalid}, {7'b0, ret &&  ret_id});
    check("result",   result,           er);
    @(posedge clk);
    if (ret) begin
      void'(pend.pop_front());
      if (ret_id) out_b--; else out_a--;
      last_res = ret_data;
    end
    if (ga) begin
      pend.push_back('{cyc + LAT, 1'b0, {a_hi, a_lo}});
      out_a++;
    end
    if (gb) begin
      pend.push_back('{cyc + LAT, 1'b1, {b_hi, b_lo}});
      out_b++;
    end
    if (ea && eb) ptr = !ptr;
    a_issued = ga;
    b_issued = gb;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    cyc = 0;
    clear_model();
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b0;
    a_hi = 4'h0; a_lo = 4'h0; b_hi = 4'h0; b_lo = 4'h0;
    @(negedge clk);

    // Reset held with A requesting.
    step();
    step();
    rst_n = 1'b1;
    a_valid = 1'b0;
    idle(1);

    // Single A issue, result three cycles later.
    a_valid = 1'b1; a_hi = 4'h1; a_lo = 4'h2;
    step();
    check("t2_ready", {7'b0, obs_a_ready}, 8'h01);
    idle(2);
    step();
    check("t2_rvalid", {7'b0, obs_a_rvalid}, 8'h01);
    check("t2_result", obs_result, 8'h12);
    idle(2);

    // Both requesting every cycle: strict alternation starting at A.
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || a_issued) begin a_hi = 4'($urandom); a_lo = 4'($urandom); end
      if (i == 0 || b_issued) begin b_hi = 4'($urandom); b_lo = 4'($urandom); end
      a_valid = 1'b1;
      b_valid = 1'b1;
      step();
      check("t3_a_grant", {7'b0, obs_a_ready}, (i % 2 == 0) ? 8'h01 : 8'h00);
      check("t3_b_grant", {7'b0, obs_b_ready}, (i % 2 == 1) ? 8'h01 : 8'h00);
    end
    idle(LAT + 1);

    // A alone saturates at MAX outstanding; a return re-opens it at once.
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      if (i == 0 || a_issued) begin a_hi = 4'($urandom); a_lo = 4'($urandom); end
      step();
      check("t4_ready", {7'b0, obs_a_ready}, (i % 3 == 2) ? 8'h00 : 8'h01);
    end
    idle(LAT + 1);

    // A issue, bubble, B issue.
    a_valid = 1'b1; a_hi = 4'hA; a_lo = 4'h5;
    step();
    idle(1);
    b_valid = 1'b1; b_hi = 4'h3; b_lo = 4'hC;
    step();
    idle(0);
    b_valid = 1'b0;
    step();
    check("t5_a_rvalid", {7'b0, obs_a_rvalid}, 8'h01);
    check("t5_a_result", obs_result, 8'hA5);
    step();
    check("t5_gap_rv", {6'b0, obs_a_rvalid, obs_b_rvalid}, 8'h00);
    check("t5_gap_hold", obs_result, 8'hA5);
    step();
    check("t5_b_rvalid", {7'b0, obs_b_rvalid}, 8'h01);
    check("t5_b_result", obs_result, 8'h3C);
    idle(2);

    // Reset with two A issues in flight: they must never return.
    a_valid = 1'b1; a_hi = 4'h9; a_lo = 4'h1;
    step();
    a_hi = 4'h9; a_lo = 4'h2;
    step();
    a_valid = 1'b0;
    rst_n = 1'b0;
    clear_model();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      check("t6_no_rvalid", {6'b0, obs_a_rvalid, obs_b_rvalid}, 8'h00);
    end
    a_valid = 1'b1; a_hi = 4'h7; a_lo = 4'hE;
    step();
    idle(2);
    step();
    check("t6_new_rvalid", {7'b0, obs_a_rvalid}, 8'h01);
    check("t6_new_result", obs_result, 8'h7E);
    idle(2);

    // Random traffic honouring the hold-until-ready rule.
    for (int i = 0; i < 400; i++) begin
      if (!(a_valid && !a_issued)) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_hi = 4'($urandom); a_lo = 4'($urandom);
      end
      if (!(b_valid && !b_issued)) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_hi = 4'($urandom); b_lo = 4'($urandom);
      end
      step();
    end
    idle(LAT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
